// File: rtl/fsk_measurement_sequencer.sv
// fsk_measurement_sequencer
//   Runs one frequency_analyzer per FSK symbol window. Each window clears the
//   analyzer, enables it for a fixed gate time, and latches its two tick sums.
//   It then decides the symbol and offers it downstream on a valid/ready port.
//
// Ports
//   clock            system clock, rising edge
//   clear            asynchronous active-low reset
//   start            begin a sequence (honoured in IDLE only)
//   abort            abandon the current sequence, return to IDLE
//   continuous       1 = start a new window automatically after each transfer
//   f0_value/f1_value analyzer FREQUENCY0/FREQUENCY1 tick sums
//   analyzer_enable  analyzer enable
//   analyzer_clear   analyzer clear, active-low
//   busy             high in every state except IDLE
//   result_valid     symbol/flags/sums are valid
//   result_ready     downstream accepts the result
//   symbol           decided symbol (0 = FREQUENCY0, 1 = FREQUENCY1)
//   symbol_error     no valid decision for this window
//   f0_sum/f1_sum    latched analyzer sums
//   window_count     accepted results, wraps at 16 bits
module fsk_measurement_sequencer #(
    parameter int unsigned WINDOW_TICKS      = 5000,
    parameter int unsigned CLEAR_TICKS       = 2,
    parameter int unsigned MIN_TICKS         = 1000,
    parameter int unsigned DOMINANCE_PERCENT = 75
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        abort,
    input  logic        continuous,
    input  logic [31:0] f0_value,
    input  logic [31:0] f1_value,
    output logic        analyzer_enable,
    output logic        analyzer_clear,
    output logic        busy,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        symbol,
    output logic        symbol_error,
    output logic [31:0] f0_sum,
    output logic [31:0] f1_sum,
    output logic [15:0] window_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MEASURE,
        S_LATCH,
        S_DECIDE,
        S_HOLD
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] tick_reg, tick_next;
    logic        transfer;

    // Decision datapath, evaluated from the latched sums during DECIDE.
    logic [32:0] total_sum;
    logic [31:0] winner;
    logic [39:0] winner_prod;
    logic [39:0] total_prod;
    logic        decide_symbol;
    logic        decide_error;

    // A transfer needs the registered valid; abort in the same cycle cancels it.
    assign transfer = (state_reg == S_HOLD) && result_valid && result_ready && !abort;

    always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg + 32'd1;
        case (state_reg)
            S_IDLE: begin
                tick_next = 32'd0;
                if (start && !abort) state_next = S_CLEAR;
            end
            S_CLEAR: begin
                if (tick_reg == 32'(CLEAR_TICKS - 1)) begin
                    state_next = S_MEASURE;
                    tick_next  = 32'd0;
                end
            end
            S_MEASURE: begin
                if (tick_reg == 32'(WINDOW_TICKS - 1)) begin
                    state_next = S_LATCH;
                    tick_next  = 32'd0;
                end
            end
            S_LATCH:  state_next = S_DECIDE;
            S_DECIDE: state_next = S_HOLD;
            S_HOLD: begin
                tick_next = 32'd0;
                if (transfer) state_next = continuous ? S_CLEAR : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (abort && state_reg != S_IDLE) begin
            state_next = S_IDLE;
            tick_next  = 32'd0;
        end
    end

    always_comb begin
        total_sum     = {1'b0, f0_sum} + {1'b0, f1_sum};
        winner        = (f1_sum > f0_sum) ? f1_sum : f0_sum;
        winner_prod   = 40'(winner) * 40'd100;
        total_prod    = 40'(total_sum) * 40'(DOMINANCE_PERCENT);
        // Equal sums fall through to symbol 0 because f1_sum > f0_sum is false.
        decide_symbol = (total_sum >= 33'(MIN_TICKS)) && (f1_sum > f0_sum);
        decide_error  = (total_sum < 33'(MIN_TICKS)) || (f0_sum == f1_sum) ||
                        (winner_prod < total_prod);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_reg       <= S_IDLE;
            tick_reg        <= 32'd0;
            analyzer_enable <= 1'b0;
            analyzer_clear  <= 1'b0;
            busy            <= 1'b0;
            result_valid    <= 1'b0;
            symbol          <= 1'b0;
            symbol_error    <= 1'b0;
            f0_sum          <= 32'd0;
            f1_sum          <= 32'd0;
            window_count    <= 16'd0;
        end else begin
            state_reg       <= state_next;
            tick_reg        <= tick_next;
            analyzer_enable <= (state_next == S_MEASURE);
            analyzer_clear  <= (state_next != S_CLEAR);
            busy            <= (state_next != S_IDLE);
            // Valid rises on the second HOLD cycle, once symbol/flags have
            // been registered, and drops on the transfer or abort edge.
            result_valid    <= (state_reg == S_HOLD) && (state_next == S_HOLD);
            // Guarded by the next state so an abort leaves the previous
            // result's sums and flags untouched.
            if (state_reg == S_LATCH && state_next == S_DECIDE) begin
                f0_sum <= f0_value;
                f1_sum <= f1_value;
            end
            if (state_reg == S_DECIDE && state_next == S_HOLD) begin
                symbol       <= decide_symbol;
                symbol_error <= decide_error;
            end
            if (transfer) window_count <= window_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fsk_measurement_sequencer.sv
// tb_fsk_measurement_sequencer
//   Drives the sequencer with directed and random windows. An analyzer model
//   accumulates the target sums over exactly WINDOW_TICKS enabled cycles, and
//   a reference decision function plus a transfer counter supply the expected
//   outputs, checked every cycle while results are presented.
module tb_fsk_measurement_sequencer;

    localparam int WIN   = 100;
    localparam int CLR   = 2;
    localparam int MINT  = 20;
    localparam int DOM   = 75;
    localparam int LAT   = CLR + WIN + 3;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        continuous = 1'b0;
    logic [31:0] f0_value = '0;
    logic [31:0] f1_value = '0;
    logic        analyzer_enable, analyzer_clear, busy, result_valid;
    logic        result_ready = 1'b0;
    logic        symbol, symbol_error;
    logic [31:0] f0_sum, f1_sum;
    logic [15:0] window_count;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          en_cnt = 0;
    int unsigned tgt0 = 0, tgt1 = 0;
    logic [15:0] exp_count;
    logic        exp_sym, exp_err;

    fsk_measurement_sequencer #(
        .WINDOW_TICKS(WIN), .CLEAR_TICKS(CLR), .MIN_TICKS(MINT), .DOMINANCE_PERCENT(DOM)
    ) dut (
        .clock(clock), .clear(clear), .start(start), .abort(abort),
        .continuous(continuous), .f0_value(f0_value), .f1_value(f1_value),
        .analyzer_enable(analyzer_enable), .analyzer_clear(analyzer_clear),
        .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
        .symbol(symbol), .symbol_error(symbol_error), .f0_sum(f0_sum),
        .f1_sum(f1_sum), .window_count(window_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Spreads target t over WIN enabled cycles so the total is exactly t.
    function automatic logic [31:0] inc(input int unsigned t, input int n);
        return (n < int'(t % WIN)) ? 32'(t / WIN + 1) : 32'(t / WIN);
    endfunction

    // Reference decision, straight from the symbol rules.
    function automatic void model_decide(input longint t0, input longint t1,
                                         output logic sym, output logic err);
        longint total = t0 + t1;
        longint w = (t0 > t1) ? t0 : t1;
        if (total < MINT || t0 == t1) begin
            sym = 1'b0;
            err = 1'b1;
        end else begin
            sym = (t1 > t0);
            err = (w * 100 < total * DOM);
        end
    endfunction

    // Analyzer model: cleared while analyzer_clear is low, accumulates while enabled.
    always @(posedge clock) begin
        if (!analyzer_clear) begin
            f0_value <= '0;
            f1_value <= '0;
            en_cnt   <= 0;
        end else if (analyzer_enable) begin
            f0_value <= f0_value + inc(tgt0, en_cnt);
            f1_value <= f1_value + inc(tgt1, en_cnt);
            en_cnt   <= en_cnt + 1;
        end
    end

    // Accepted results: valid and ready on an edge, unless abort cancels it.
    always @(posedge clock or negedge clear) begin
        if (!clear) exp_count <= '0;
        else if (result_valid && result_ready && !abort) exp_count <= exp_count + 16'd1;
    end

    // Per-cycle compare against the model.
    always @(negedge clock) begin
        if (clear) begin
            chk("window_count", window_count, exp_count);
            if (result_valid) begin
                model_decide(tgt0, tgt1, exp_sym, exp_err);
                chk("symbol", symbol, exp_sym);
                chk("symbol_error", symbol_error, exp_err);
                chk("f0_sum", f0_sum, tgt0);
                chk("f1_sum", f1_sum, tgt1);
                chk("enable_in_hold", analyzer_enable, 0);
                chk("enabled_cycles", en_cnt, WIN);
            end
        end
    end

    // Wait (bounded) for result_valid; returns the edge index it rose after.
    task automatic wait_valid(output int m);
        int n = 0;
        while (!result_valid && n < 400) begin
            @(negedge clock);
            n++;
            start = (n == 30);   // a start pulse while busy must be ignored
        end
        start = 1'b0;
        if (!result_valid) chk("valid_timeout", 0, 1);
        m = cyc;
    endtask

    // One window. Called at a negedge; do_start=0 means the window was
    // already launched by a continuous-mode transfer on the previous edge.
    task automatic run_window(input int unsigned t0, input int unsigned t1,
                              input bit do_start, input int rdelay, input bit cont_after);
        int k, m;
        tgt0 = t0;
        tgt1 = t1;
        if (do_start) begin
            start = 1'b1;
            k = cyc + 1;
        end else begin
            k = cyc;
        end
        wait_valid(m);
        chk("latency", m, k + LAT);
        repeat (rdelay) @(negedge clock);
        continuous   = cont_after;
        result_ready = 1'b1;
        @(negedge clock);
        result_ready = 1'b0;
        chk("valid_drop", result_valid, 0);
        chk("busy_after", busy, cont_after);
        chk("clear_after", analyzer_clear, !cont_after);
        $display("window f0=%0d f1=%0d sym=%0d err=%0d count=%0d", t0, t1, symbol, symbol_error, window_count);
    endtask

    initial begin
        int unsigned a, b;
        bit prev_cont;
        int m;

        // Reset state
        #1;
        chk("rst_enable", analyzer_enable, 0);
        chk("rst_aclear", analyzer_clear, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_count", window_count, 0);
        repeat (3) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);

        // Directed windows with literal expectations
        run_window(80, 0, 1, 0, 0);
        chk("t1_sym", symbol, 0);  chk("t1_err", symbol_error, 0);
        chk("t1_f0", f0_sum, 80);  chk("t1_count", window_count, 1);
        run_window(10, 70, 1, 3, 0);
        chk("t2a_sym", symbol, 1); chk("t2a_err", symbol_error, 0);
        run_window(30, 50, 1, 0, 0);
        chk("t2b_sym", symbol, 1); chk("t2b_err", symbol_error, 1);
        run_window(40, 40, 1, 0, 0);
        chk("t3a_sym", symbol, 0); chk("t3a_err", symbol_error, 1);
        run_window(5, 10, 1, 0, 0);
        chk("t3b_sym", symbol, 0); chk("t3b_err", symbol_error, 1);

        // Continuous mode with 50 cycles of backpressure, then a stop
        continuous = 1'b1;
        run_window(300, 20, 1, 50, 1);
        run_window(15, 250, 0, 2, 0);
        chk("t4_count", window_count, 7);

        // Abort in MEASURE
        tgt0 = 90; tgt1 = 10;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (52) @(negedge clock);
        chk("t5_enable_mid", analyzer_enable, 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("t5_enable", analyzer_enable, 0);
        chk("t5_busy", busy, 0);
        m = 0;
        repeat (150) begin
            @(negedge clock);
            if (result_valid) m++;
        end
        chk("t5_no_valid", m, 0);
        chk("t5_count", window_count, 7);

        // Abort together with ready in HOLD: no transfer
        start = 1'b1;
        wait_valid(m);
        abort = 1'b1;
        result_ready = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        result_ready = 1'b0;
        chk("t5b_valid", result_valid, 0);
        chk("t5b_busy", busy, 0);
        chk("t5b_count", window_count, 7);

        // Abort in IDLE beats start
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);

        // Async clear mid-HOLD, then a normal restart
        start = 1'b1;
        wait_valid(m);
        #2 clear = 1'b0;
        #1;
        chk("t6_valid", result_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_aclear", analyzer_clear, 0);
        chk("t6_f0", f0_sum, 0);
        chk("t6_sym", symbol, 0);
        chk("t6_count", window_count, 0);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        run_window(120, 700, 1, 1, 0);

        // Random windows
        prev_cont = 1'b0;
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom_range(0, 15);  b = $urandom_range(0, 15); end
                1: begin a = $urandom_range(20, 400); b = a; end
                2: begin a = $urandom_range(200, 900); b = $urandom_range(0, 100); end
                default: begin a = $urandom_range(0, 600); b = $urandom_range(0, 600); end
            endcase
            if (i == 9) begin
                run_window(a, b, !prev_cont, $urandom_range(0, 20), 1'b0);
            end else begin
                run_window(a, b, !prev_cont, $urandom_range(0, 20), 1'($urandom_range(0, 1)));
            end
            prev_cont = continuous;
        end
        chk("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
